// File: rtl/binary_search_driver_if.sv
// Handshake/bus bundle between the binary-search driver and the comparator/controller side.
interface binary_search_driver_if #(
    parameter int W = 3
);
    logic         start;
    logic         gt;
    logic         eq;
    logic         lt;
    logic [W-1:0] guess;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] result;
    logic [3:0]   steps;

    modport master (
        input  start, gt, eq, lt,
        output guess, busy, done, error, result, steps
    );

    modport slave (
        output start, gt, eq, lt,
        input  guess, busy, done, error, result, steps
    );
endinterface

// File: rtl/binary_search_driver.sv
// Binary search of a comparator's A operand by probing B; optional FLAG_ONEHOT_CHECK_EN rejects non-one-hot flags.
// Latency: first guess one cycle after start, done/error k+1 cycles after start for a search resolved on probe k.
// Backpressure: none; start is ignored while busy, flags must be valid combinationally every PROBE cycle.
module binary_search_driver #(
    parameter int W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    binary_search_driver_if.master bus
);
    typedef enum logic {S_IDLE, S_PROBE} state_t;

    localparam logic [W-1:0] MAXV = {W{1'b1}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state, w_state_nx;
    logic [W-1:0] r_lo, r_hi, r_guess, r_result;
    logic [W-1:0] w_lo_nx, w_hi_nx, w_guess_nx, w_result_nx;
    logic [3:0]   r_count, r_steps, w_count_nx, w_steps_nx;
    logic         r_busy, r_done, r_error;
    logic         w_busy_nx, w_done_nx, w_error_nx;
    logic [W-1:0] w_lo_new, w_hi_new;
    logic [W:0]   w_sum;
    logic         w_fail, w_move, w_stall, w_flag_bad;

`ifdef FLAG_ONEHOT_CHECK_EN
    assign w_flag_bad = !(({bus.gt, bus.eq, bus.lt} == 3'b100) ||
                          ({bus.gt, bus.eq, bus.lt} == 3'b010) ||
                          ({bus.gt, bus.eq, bus.lt} == 3'b001));
`else
    assign w_flag_bad = 1'b0;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_lo_nx     = r_lo;
        w_hi_nx     = r_hi;
        w_guess_nx  = r_guess;
        w_result_nx = r_result;
        w_count_nx  = r_count;
        w_steps_nx  = r_steps;
        w_done_nx   = 1'b0;
        w_error_nx  = 1'b0;
        w_fail      = 1'b0;
        w_move      = 1'b0;
        w_stall     = 1'b0;
        w_lo_new    = r_lo;
        w_hi_new    = r_hi;
        w_sum       = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_lo_nx    = '0;
                    w_hi_nx    = MAXV;
                    w_guess_nx = MAXV >> 1;
                    w_count_nx = 4'd1;
                    w_state_nx = S_PROBE;
                end
            end
            S_PROBE: begin
                if (w_flag_bad) begin
                    w_fail = 1'b1;
                end else if (bus.eq) begin
                    w_result_nx = r_guess;
                    w_steps_nx  = r_count;
                    w_done_nx   = 1'b1;
                    w_state_nx  = S_IDLE;
                end else if (bus.gt) begin
                    if (r_guess == MAXV) w_fail = 1'b1;
                    else begin
                        w_lo_new = r_guess + ONE;
                        w_move   = 1'b1;
                    end
                end else if (bus.lt) begin
                    if (r_guess == '0) w_fail = 1'b1;
                    else begin
                        w_hi_new = r_guess - ONE;
                        w_move   = 1'b1;
                    end
                end else begin
                    w_stall = 1'b1;
                end

                // Interval collapse means the target moved; count saturation guards a stuck comparator.
                if (w_move && (w_lo_new > w_hi_new)) begin
                    w_fail = 1'b1;
                end else if ((w_move || w_stall) && (r_count == 4'd15)) begin
                    w_fail = 1'b1;
                end else if (w_move || w_stall) begin
                    w_count_nx = r_count + 4'd1;
                    if (w_move) begin
                        w_sum      = {1'b0, w_lo_new} + {1'b0, w_hi_new};
                        w_lo_nx    = w_lo_new;
                        w_hi_nx    = w_hi_new;
                        w_guess_nx = W'(w_sum >> 1);
                    end
                end

                if (w_fail) begin
                    w_error_nx = 1'b1;
                    w_steps_nx = r_count;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        w_busy_nx = (w_state_nx == S_PROBE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_count  <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_lo     <= w_lo_nx;
            r_hi     <= w_hi_nx;
            r_guess  <= w_guess_nx;
            r_result <= w_result_nx;
            r_count  <= w_count_nx;
            r_steps  <= w_steps_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_error  <= w_error_nx;
        end
    end

    assign bus.guess  = r_guess;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.error  = r_error;
    assign bus.result = r_result;
    assign bus.steps  = r_steps;
endmodule

// File: tb/tb_binary_search_driver.sv
// Bench for binary_search_driver at W=3 with an ideal comparator and a scoreboard of guesses and outcomes.
module tb_binary_search_driver;
    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        bit is_err;
        int result;
        int steps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   target = 0;
    int   flag_mode = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_result = 0;
    exp_t exp_q[$];
    int   gq[$];

    binary_search_driver_if #(.W(W)) bif ();
    binary_search_driver #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal zero-latency comparator, with overrides for corrupted flag patterns.
    always_comb begin
        bif.gt = 1'b0;
        bif.eq = 1'b0;
        bif.lt = 1'b0;
        case (flag_mode)
            1: begin bif.gt = 1'b1; bif.eq = 1'b1; end
            2: ;
            default: begin
                bif.gt = (target > int'(bif.guess));
                bif.eq = (target == int'(bif.guess));
                bif.lt = (target < int'(bif.guess));
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_err, input int res, input int steps);
        exp_t e;
        e.is_err = is_err;
        e.steps  = steps;
        if (is_err) e.result = last_result;
        else begin
            e.result    = res;
            last_result = res;
        end
        exp_q.push_back(e);
    endtask

    task automatic model_search(input int t);
        int lo = 0, hi = MAXV, g, n = 1;
        g = (lo + hi) / 2;
        forever begin
            gq.push_back(g);
            if (g == t) break;
            if (t > g) lo = g + 1;
            else       hi = g - 1;
            g = (lo + hi) / 2;
            n++;
        end
        push_exp(1'b0, t, n);
    endtask

    task automatic launch();
        @(negedge clk);
        #1;
        bif.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
    endtask

    task automatic wait_end();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bif.done === 1'b1 || bif.error === 1'b1) found = 1'b1;
        end
        chk("end_seen", found, 1);
        chk("busy_low_at_end", bif.busy, 0);
        @(negedge clk);
        #1;
    endtask

    // variant 1: target switches to 6 after the first probe; variant 2: start re-pulsed while busy
    task automatic run(input int t, input int variant);
        target = t;
        launch();
        if (variant == 1) begin
            @(posedge clk);
            #1 target = 6;
        end else if (variant == 2) begin
            @(posedge clk);
            #1 bif.start = 1'b1;
            @(posedge clk);
            #1 bif.start = 1'b0;
        end
        wait_end();
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (bif.busy === 1'b1) begin
            if (gq.size() == 0) chk("guess_pending", gq.size(), 1);
            else chk("guess", bif.guess, gq.pop_front());
        end
        if (bif.done === 1'b1 || bif.error === 1'b1) begin
            if (exp_q.size() == 0) chk("end_expected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("error_flag", bif.error, e.is_err);
                chk("done_flag", bif.done, !e.is_err);
                chk("result", bif.result, e.result);
                chk("steps", bif.steps, e.steps);
                chk("latency", cyc - start_cyc, e.steps + 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bif.start = 1'b1;
        target    = 5;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        bif.start = 1'b0;
        chk("rst_guess", bif.guess, 0);
        chk("rst_result", bif.result, 0);
        chk("rst_steps", bif.steps, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_error", bif.error, 0);
        @(posedge clk);
        #1;
        chk("idle_busy", bif.busy, 0);

        gq.push_back(3); gq.push_back(5); push_exp(1'b0, 5, 2);
        run(5, 0);
        gq.push_back(3); gq.push_back(5); gq.push_back(6); gq.push_back(7); push_exp(1'b0, 7, 4);
        run(7, 0);
        gq.push_back(3); gq.push_back(1); gq.push_back(0); push_exp(1'b0, 0, 3);
        run(0, 0);
        gq.push_back(3); push_exp(1'b0, 3, 1);
        run(3, 0);

        for (int t = 0; t <= MAXV; t++) begin
            model_search(t);
            run(t, 0);
        end

        model_search(4);
        run(4, 0);
        gq.push_back(3); gq.push_back(1); gq.push_back(2); push_exp(1'b1, 0, 3);
        run(2, 1);
        chk("result_held_after_error", bif.result, 4);

        gq.push_back(3); gq.push_back(5); gq.push_back(6); gq.push_back(7); push_exp(1'b0, 7, 4);
        run(7, 2);
        @(posedge clk);
        #1;
        chk("no_restart_after_busy_start", bif.busy, 0);

        target = 7;
        gq.push_back(3); gq.push_back(5);
        launch();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_result = 0;
        chk("midrst_busy", bif.busy, 0);
        chk("midrst_guess", bif.guess, 0);
        chk("midrst_done", bif.done, 0);
        chk("midrst_error", bif.error, 0);
        chk("midrst_result", bif.result, 0);
        chk("midrst_steps", bif.steps, 0);
        chk("midrst_guess_q", gq.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_stays_idle", bif.busy, 0);

        model_search(6);
        run(6, 0);

`ifdef FLAG_ONEHOT_CHECK_EN
        flag_mode = 1;
        gq.push_back(3); push_exp(1'b1, 0, 1);
        run(5, 0);
        flag_mode = 2;
        gq.push_back(3); push_exp(1'b1, 0, 1);
        run(5, 0);
`else
        flag_mode = 1;
        gq.push_back(3); push_exp(1'b0, 3, 1);
        run(5, 0);
        flag_mode = 2;
        for (int i = 0; i < 15; i++) gq.push_back(3);
        push_exp(1'b1, 0, 15);
        run(5, 0);
`endif
        flag_mode = 0;
        chk("result_after_bad_flags", bif.result, last_result);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("guess_queue_drained", gq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
